// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single write port of the register file between two writeback
//   sources: A (ALU result) and B (memory load data). Each source feeds a
//   DEPTH-entry FIFO through a valid/ready handshake. A round-robin arbiter
//   drains the FIFOs and issues at most one registered write per cycle.
//
// Parameters
//   DEPTH  entries per source FIFO (power of 2, >= 2)
//   AW     register address width
//   DW     data width
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   alu_valid/alu_ready        source A handshake (ready = FIFO not full)
//   alu_rd, alu_data           source A destination register and result
//   mem_valid/mem_ready        source B handshake (ready = FIFO not full)
//   mem_rd, mem_data           source B destination register and load data
//   rf_wrt, rf_rd, rf_data     registered register-file write port
//   idle                       both FIFOs empty and no write in flight
//
// Optional feature (macro RF_HAZARD_CHK_EN)
//   chk_rs1, chk_rs2           decode-stage source registers to check
//   hazard_rs1, hazard_rs2     combinational: register has a pending write
//                              (queued in either FIFO or on rf_* this cycle)

module regfile_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW    = 6,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_data,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic [AW-1:0] mem_rd,
  input  logic [DW-1:0] mem_data,
  output logic          rf_wrt,
  output logic [AW-1:0] rf_rd,
  output logic [DW-1:0] rf_data,
`ifdef RF_HAZARD_CHK_EN
  input  logic [AW-1:0] chk_rs1,
  input  logic [AW-1:0] chk_rs2,
  output logic          hazard_rs1,
  output logic          hazard_rs2,
`endif
  output logic          idle
);

  localparam int PW = $clog2(DEPTH);

  // Last-grant pointer values
  localparam logic [0:0] LAST_A = 1'b0;
  localparam logic [0:0] LAST_B = 1'b1;

  // Pointers carry an extra wrap bit so full and empty are distinguishable
  logic [PW:0]   a_wp, a_rp, b_wp, b_rp;
  logic [AW-1:0] a_rd_mem   [DEPTH];
  logic [DW-1:0] a_data_mem [DEPTH];
  logic [AW-1:0] b_rd_mem   [DEPTH];
  logic [DW-1:0] b_data_mem [DEPTH];

  logic       a_empty, a_full, b_empty, b_full;
  logic       a_push, b_push, grant_a, grant_b;
  logic [0:0] last_grant;

  always_comb begin
    a_empty = (a_wp == a_rp);
    b_empty = (b_wp == b_rp);
    a_full  = (a_wp[PW-1:0] == a_rp[PW-1:0]) && (a_wp[PW] != a_rp[PW]);
    b_full  = (b_wp[PW-1:0] == b_rp[PW-1:0]) && (b_wp[PW] != b_rp[PW]);
  end

  assign alu_ready = !a_full;
  assign mem_ready = !b_full;

  // A full FIFO never accepts, even when the same edge pops it
  assign a_push = alu_valid && !a_full;
  assign b_push = mem_valid && !b_full;

  // On contention the source not granted last wins
  always_comb begin
    grant_a = !a_empty && (b_empty || (last_grant == LAST_B));
    grant_b = !b_empty && (a_empty || (last_grant == LAST_A));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_wp <= '0;
      a_rp <= '0;
      b_wp <= '0;
      b_rp <= '0;
    end else begin
      if (a_push)  a_wp <= a_wp + 1'b1;
      if (b_push)  b_wp <= b_wp + 1'b1;
      if (grant_a) a_rp <= a_rp + 1'b1;
      if (grant_b) b_rp <= b_rp + 1'b1;
    end
  end

  // FIFO storage needs no reset: entries are only read behind the pointers
  always_ff @(posedge clk) begin
    if (a_push) begin
      a_rd_mem[a_wp[PW-1:0]]   <= alu_rd;
      a_data_mem[a_wp[PW-1:0]] <= alu_data;
    end
    if (b_push) begin
      b_rd_mem[b_wp[PW-1:0]]   <= mem_rd;
      b_data_mem[b_wp[PW-1:0]] <= mem_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wrt     <= 1'b0;
      rf_rd      <= '0;
      rf_data    <= '0;
      last_grant <= LAST_B;
    end else begin
      rf_wrt <= grant_a || grant_b;
      if (grant_a) begin
        rf_rd      <= a_rd_mem[a_rp[PW-1:0]];
        rf_data    <= a_data_mem[a_rp[PW-1:0]];
        last_grant <= LAST_A;
      end else if (grant_b) begin
        rf_rd      <= b_rd_mem[b_rp[PW-1:0]];
        rf_data    <= b_data_mem[b_rp[PW-1:0]];
        last_grant <= LAST_B;
      end
    end
  end

  assign idle = a_empty && b_empty && !rf_wrt;

`ifdef RF_HAZARD_CHK_EN
  logic [PW:0]   a_cnt, b_cnt;
  logic [PW-1:0] a_off, b_off;

  assign a_cnt = a_wp - a_rp;
  assign b_cnt = b_wp - b_rp;

  // Slot i holds a live entry when its distance from the read pointer is
  // below the occupancy
  always_comb begin
    hazard_rs1 = rf_wrt && (rf_rd == chk_rs1);
    hazard_rs2 = rf_wrt && (rf_rd == chk_rs2);
    a_off      = '0;
    b_off      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      a_off = PW'(i) - a_rp[PW-1:0];
      b_off = PW'(i) - b_rp[PW-1:0];
      if ({1'b0, a_off} < a_cnt) begin
        if (a_rd_mem[i] == chk_rs1) hazard_rs1 = 1'b1;
        if (a_rd_mem[i] == chk_rs2) hazard_rs2 = 1'b1;
      end
      if ({1'b0, b_off} < b_cnt) begin
        if (b_rd_mem[i] == chk_rs1) hazard_rs1 = 1'b1;
        if (b_rd_mem[i] == chk_rs2) hazard_rs2 = 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int AW    = 6;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alu_valid, mem_valid;
  logic          alu_ready, mem_ready;
  logic [AW-1:0] alu_rd, mem_rd, rf_rd;
  logic [DW-1:0] alu_data, mem_data, rf_data;
  logic          rf_wrt, idle;
`ifdef RF_HAZARD_CHK_EN
  logic [AW-1:0] chk_rs1 = '0, chk_rs2 = '0;
  logic          hazard_rs1, hazard_rs2;
`endif

  regfile_wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .rf_wrt(rf_wrt), .rf_rd(rf_rd), .rf_data(rf_data),
`ifdef RF_HAZARD_CHK_EN
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .hazard_rs1(hazard_rs1), .hazard_rs2(hazard_rs2),
`endif
    .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } ent_t;

  // Reference model: two queues, who-was-served-last, expected write port
  ent_t          qa[$], qb[$];
  bit            last_was_b;
  logic          exp_wrt;
  logic [AW-1:0] exp_rd;
  logic [DW-1:0] exp_data;
  int            accepted, written;
  logic [AW-1:0] wr_log[$];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit pending(input logic [AW-1:0] r);
    bit h = exp_wrt && (exp_rd == r);
    foreach (qa[i]) if (qa[i].rd == r) h = 1'b1;
    foreach (qb[i]) if (qb[i].rd == r) h = 1'b1;
    return h;
  endfunction

  task automatic model_clear();
    qa.delete(); qb.delete();
    last_was_b = 1'b1;
    exp_wrt = 1'b0; exp_rd = '0; exp_data = '0;
    accepted = 0; written = 0;
  endtask

  // One clock cycle; called #1 after a posedge
  task automatic step(input bit av, input logic [AW-1:0] ard, input logic [DW-1:0] adat,
                      input bit mv, input logic [AW-1:0] mrd, input logic [DW-1:0] mdat,
                      output bit acc_a, output bit acc_b);
    ent_t e;
    bit   take_a, take_b;
    alu_valid = av; alu_rd = ard; alu_data = adat;
    mem_valid = mv; mem_rd = mrd; mem_data = mdat;
    #1;
    check("alu_ready", alu_ready, qa.size() < DEPTH);
    check("mem_ready", mem_ready, qb.size() < DEPTH);
    check("idle", idle, qa.size() == 0 && qb.size() == 0 && !exp_wrt);
`ifdef RF_HAZARD_CHK_EN
    check("hazard_rs1", hazard_rs1, pending(chk_rs1));
    check("hazard_rs2", hazard_rs2, pending(chk_rs2));
`endif
    acc_a = av && qa.size() < DEPTH;
    acc_b = mv && qb.size() < DEPTH;
    // Round robin: alone wins; on contention the one not served last wins
    take_a = 0; take_b = 0;
    if (qa.size() > 0 && qb.size() > 0) begin
      if (last_was_b) take_a = 1; else take_b = 1;
    end else if (qa.size() > 0) take_a = 1;
    else if (qb.size() > 0) take_b = 1;
    exp_wrt = take_a || take_b;
    if (take_a) begin e = qa.pop_front(); last_was_b = 0; exp_rd = e.rd; exp_data = e.data; end
    if (take_b) begin e = qb.pop_front(); last_was_b = 1; exp_rd = e.rd; exp_data = e.data; end
    if (acc_a) begin qa.push_back('{ard, adat}); accepted++; end
    if (acc_b) begin qb.push_back('{mrd, mdat}); accepted++; end
    @(posedge clk); #1;
    check("rf_wrt", rf_wrt, exp_wrt);
    check("rf_rd", rf_rd, exp_rd);
    check("rf_data", rf_data, exp_data);
    if (rf_wrt === 1'b1) begin written++; wr_log.push_back(rf_rd); end
  endtask

  task automatic idle_step();
    bit x, y;
    step(0, '0, '0, 0, '0, '0, x, y);
  endtask

  task automatic do_reset();
    alu_valid = 0; mem_valid = 0; alu_rd = '0; mem_rd = '0; alu_data = '0; mem_data = '0;
    rst_n = 0;
    #1;
    check("rst_rf_wrt", rf_wrt, 1'b0);
    check("rst_rf_rd", rf_rd, '0);
    check("rst_rf_data", rf_data, '0);
    check("rst_alu_ready", alu_ready, 1'b1);
    check("rst_mem_ready", mem_ready, 1'b1);
    check("rst_idle", idle, 1'b1);
`ifdef RF_HAZARD_CHK_EN
    check("rst_hazard_rs1", hazard_rs1, 1'b0);
    check("rst_hazard_rs2", hazard_rs2, 1'b0);
`endif
    model_clear();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  initial begin
    bit aa, ab;
    int an, bn, wd;
    rst_n = 0;
    @(posedge clk); #1;
    do_reset();

    // Single ALU writeback: accepted at edge N, visible during N+1
    wr_log.delete();
    step(1, 6'd5, 32'h0000_00AA, 0, '0, '0, aa, ab);
    check("t1_accept_no_write", rf_wrt, 1'b0);
    idle_step();
    check("t1_wrt", rf_wrt, 1'b1);
    check("t1_rd", rf_rd, 6'd5);
    check("t1_data", rf_data, 32'hAA);
    idle_step();
    check("t1_wrt_drop", rf_wrt, 1'b0);
    check("t1_idle", idle, 1'b1);

    // Both sources every cycle: interleave starting with A
    do_reset();
    wr_log.delete();
    an = 1; bn = 33;
    for (int i = 0; i < 12; i++) begin
      step(1, AW'(an), DW'(an * 16), 1, AW'(bn), DW'(bn * 16), aa, ab);
      if (aa) an++;
      if (ab) bn++;
      if (i >= 1) check("t2_sustained_wrt", rf_wrt, 1'b1);
    end
    check("t2_seq0", wr_log[0], 6'd1);
    check("t2_seq1", wr_log[1], 6'd33);
    check("t2_seq2", wr_log[2], 6'd2);
    check("t2_seq3", wr_log[3], 6'd34);
    for (int i = 0; i < 6; i++) idle_step();
    check("t2_conserve", written, accepted);

    // Load source backs up under ALU contention
    do_reset();
    bn = 40;
    for (int i = 0; i < 6; i++) begin
      step(1, 6'd10, DW'(i), 1, AW'(bn), DW'(bn), aa, ab);
      if (ab) bn++;
    end
    check("t3_mem_full", mem_ready, 1'b0);
    for (int i = 0; i < 6; i++) idle_step();
    check("t3_conserve", written, accepted);

    // Async reset with entries queued
    step(1, 6'd3, 32'h33, 1, 6'd4, 32'h44, aa, ab);
    step(1, 6'd5, 32'h55, 1, 6'd6, 32'h66, aa, ab);
    #2;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle_step();
      check("t4_no_stale_write", rf_wrt, 1'b0);
    end

`ifdef RF_HAZARD_CHK_EN
    // Pending rd=7 flags rs1 until its write has left the port
    chk_rs1 = 6'd7; chk_rs2 = 6'd8;
    step(1, 6'd7, 32'h77, 0, '0, '0, aa, ab);
    for (int i = 0; i < 3; i++) idle_step();
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
`ifdef RF_HAZARD_CHK_EN
      chk_rs1 = AW'($urandom_range(0, 7));
      chk_rs2 = AW'($urandom_range(0, 7));
`endif
      step($urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 2) != 0, AW'($urandom_range(0, 7)), $urandom, aa, ab);
      if (i == 200) begin
        #2;
        do_reset();
      end
    end
    wd = 0;
    while ((qa.size() != 0 || qb.size() != 0) && wd < 20) begin idle_step(); wd++; end
    idle_step();
    check("rand_drained", wd < 20, 1'b1);
    check("rand_conserve", written, accepted);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
